angle_read_seq: RTL and testbench
=================================

ANGLE_READ_SEQ -- requirements
Module: angle_read_seq

Interface
REQ-001 SHALL have parameter POLL_DIV, default 24'd100000: clk cycles between poll ticks.
REQ-002 SHALL have parameter TIMEOUT, default 16'd32767: maximum clk cycles from wrt_cmd to spi_done.
REQ-003 SHALL have parameter READ_CMD, default 16'hA000: angle read command word.
REQ-004 SHALL have parameter NOP_CMD, default 16'h0000: dummy word that clocks out the previous response.
REQ-005 SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  async active-low reset.
REQ-008 en  input  1  level; enables periodic polling.
REQ-009 cal_load  input  1  pulse; loads cal_offset into offset register.
REQ-010 cal_offset  input  16  zero-angle calibration value.
REQ-011 spi_done  input  1  1-cycle frame-complete pulse from SPI master.
REQ-012 spi_resp  input  16  parallel MISO word from SPI master, valid when spi_done=1.
REQ-013 wrt_cmd  output  1  1-cycle pulse starting an SPI frame.
REQ-014 spi_cmd  output  16  command word to SPI master, registered.
REQ-015 angle  output  16  calibrated angle, registered.
REQ-016 angle_vld  output  1  1-cycle pulse, angle updated.
REQ-017 busy  output  1  high from wrt_cmd of first frame until return to WAIT_TICK/IDLE.
REQ-018 timeout_err  output  1  sticky: spi_done missing within TIMEOUT.
REQ-019 overrun  output  1  sticky: poll tick arrived while busy.

Function
REQ-020 SHALL implement states IDLE, WAIT_TICK, SEND_RD, WAIT_RD, SEND_NOP, WAIT_NOP, PUBLISH.
REQ-021 IDLE: tick counter held at 0; en=1 -> WAIT_TICK.
REQ-022 WAIT_TICK: tick counter increments each cycle; at POLL_DIV-1 it wraps to 0 and the FSM goes to SEND_RD; en=0 -> IDLE.
REQ-023 Tick counter SHALL run in every non-IDLE state; a wrap while busy=1 SHALL set overrun and be dropped (no queued tick).
REQ-024 SEND_RD: spi_cmd=READ_CMD, wrt_cmd=1 for exactly one cycle, timeout counter cleared -> WAIT_RD.
REQ-025 WAIT_RD: spi_resp ignored (stale out-of-frame data); spi_done -> SEND_NOP.
REQ-026 SEND_NOP: spi_cmd=NOP_CMD, wrt_cmd=1 one cycle, timeout counter cleared -> WAIT_NOP.
REQ-027 WAIT_NOP: on spi_done capture spi_resp into raw register -> PUBLISH.
REQ-028 PUBLISH: angle <= raw - offset, modulo 2^16 (wrap, no saturation); angle_vld=1 one cycle; timeout_err cleared; -> WAIT_TICK if en=1 else IDLE.
REQ-029 Latency: angle_vld SHALL assert exactly 1 cycle after the spi_done that ends the NOP frame.
REQ-030 spi_cmd SHALL hold its value through the frame (changes only in SEND_RD/SEND_NOP).
REQ-031 Timeout counter SHALL increment in WAIT_RD/WAIT_NOP; reaching TIMEOUT without spi_done SHALL set timeout_err, abandon the pair and go to WAIT_TICK (IDLE if en=0); no angle_vld.
REQ-032 spi_done in the same cycle the timeout counter reaches TIMEOUT SHALL win (no error).
REQ-033 en deasserted during WAIT_RD/WAIT_NOP SHALL not abort: current frame completes, then -> IDLE without PUBLISH and without the second frame.
REQ-034 spi_done received in IDLE, WAIT_TICK or PUBLISH SHALL be ignored.
REQ-035 cal_load SHALL update offset in any state; cal_load in the PUBLISH cycle SHALL not affect that result (old offset used).
REQ-036 Only one wrt_cmd outstanding at any time; minimum 1 cycle between spi_done and next wrt_cmd.

Reset
REQ-037 On rst_n=0: state IDLE, all counters 0, offset 0, raw 0, angle 16'h0000, spi_cmd NOP_CMD, wrt_cmd 0, angle_vld 0, busy 0, timeout_err 0, overrun 0.
REQ-038 Reset mid-frame SHALL return to IDLE immediately; no angle_vld; resumes on first tick after en.

Verification
REQ-039 en=1, offset 0, SPI model returns 16'h1234 on NOP frame -> wrt_cmd with 16'hA000, then 16'h0000, angle=16'h1234, single angle_vld.
REQ-040 cal_offset=16'h0100 loaded, raw 16'h0080 -> angle=16'hFF80 (wrap).
REQ-041 SPI model never pulses spi_done on first frame -> timeout_err=1 after TIMEOUT cycles, no angle_vld, next tick retries, successful pair clears timeout_err.
REQ-042 POLL_DIV=8 with frames longer than 8 cycles -> overrun=1, no second wrt_cmd while busy.
REQ-043 en dropped during WAIT_RD -> frame finishes, no NOP frame, IDLE, busy=0.
REQ-044 rst_n pulsed in WAIT_NOP -> all outputs at REQ-037 values next edge; cal_load coincident with PUBLISH uses old offset.

Source files
------------

// File: rtl/angle_read_seq.sv
// Periodic two-frame angle read: READ command, then NOP frame that clocks out the response.
// The NOP response is calibrated and published with a one-cycle strobe.
module angle_read_seq #(
   parameter logic [23:0] POLL_DIV = 24'd100000,
   parameter logic [15:0] TIMEOUT  = 16'd32767,
   parameter logic [15:0] READ_CMD = 16'hA000,
   parameter logic [15:0] NOP_CMD  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        cal_load,
   input  logic [15:0] cal_offset,
   input  logic        spi_done,
   input  logic [15:0] spi_resp,
   output logic        wrt_cmd,
   output logic [15:0] spi_cmd,
   output logic [15:0] angle,
   output logic        angle_vld,
   output logic        busy,
   output logic        timeout_err,
   output logic        overrun
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      SEND_RD,
      WAIT_RD,
      SEND_NOP,
      WAIT_NOP,
      PUBLISH
   } state_t;

   state_t      state;
   logic [23:0] tick_cnt;
   logic [15:0] to_cnt;
   logic [15:0] offset;
   logic        tick;
   logic        to_hit;

   assign tick   = (state != IDLE) && (tick_cnt == POLL_DIV - 24'd1);
   // Frame is overdue when the counter would reach TIMEOUT this cycle; spi_done is checked first.
   assign to_hit = (to_cnt == TIMEOUT - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tick_cnt    <= 24'd0;
         to_cnt      <= 16'd0;
         offset      <= 16'd0;
         angle       <= 16'h0000;
         spi_cmd     <= NOP_CMD;
         wrt_cmd     <= 1'b0;
         angle_vld   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         wrt_cmd   <= 1'b0;
         angle_vld <= 1'b0;

         if (cal_load)
            offset <= cal_offset;

         if (state == IDLE || tick)
            tick_cnt <= 24'd0;
         else
            tick_cnt <= tick_cnt + 24'd1;

         // Ticks landing in a busy state are dropped, only flagged.
         if (tick && state != WAIT_TICK)
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (en)
                  state <= WAIT_TICK;
            end

            WAIT_TICK: begin
               if (!en) begin
                  state <= IDLE;
               end else if (tick) begin
                  state   <= SEND_RD;
                  spi_cmd <= READ_CMD;
                  wrt_cmd <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            SEND_RD: begin
               to_cnt <= 16'd0;
               state  <= WAIT_RD;
            end

            WAIT_RD: begin
               if (spi_done) begin
                  if (en) begin
                     state   <= SEND_NOP;
                     spi_cmd <= NOP_CMD;
                     wrt_cmd <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (to_hit) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= en ? WAIT_TICK : IDLE;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end

            SEND_NOP: begin
               to_cnt <= 16'd0;
               state  <= WAIT_NOP;
            end

            WAIT_NOP: begin
               if (spi_done) begin
                  if (en) begin
                     // Raw response is calibrated on capture so the strobe lands in PUBLISH.
                     angle       <= spi_resp - offset;
                     angle_vld   <= 1'b1;
                     timeout_err <= 1'b0;
                     state       <= PUBLISH;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (to_hit) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= en ? WAIT_TICK : IDLE;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end

            PUBLISH: begin
               busy  <= 1'b0;
               state <= en ? WAIT_TICK : IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_angle_read_seq.sv
// Directed bench for angle_read_seq: SPI slave responses driven inline, expected
// command words and angles queued as stimulus is issued and popped as the DUT produces them.
`timescale 1ns/1ps
module tb_angle_read_seq;

   localparam int TO = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cal_load = 1'b0;
   logic [15:0] cal_offset = 16'h0000;
   logic        spi_done = 1'b0;
   logic [15:0] spi_resp = 16'hDEAD;
   logic        wrt_cmd;
   logic [15:0] spi_cmd;
   logic [15:0] angle;
   logic        angle_vld;
   logic        busy;
   logic        timeout_err;
   logic        overrun;

   int checks = 0;
   int failures = 0;
   int vld_count = 0;
   int exp_vld = 0;
   logic [15:0] cmd_q[$];
   logic [15:0] ang_q[$];

   angle_read_seq #(
      .POLL_DIV (24'd8),
      .TIMEOUT  (16'(TO)),
      .READ_CMD (16'hA000),
      .NOP_CMD  (16'h0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cal_load    (cal_load),
      .cal_offset  (cal_offset),
      .spi_done    (spi_done),
      .spi_resp    (spi_resp),
      .wrt_cmd     (wrt_cmd),
      .spi_cmd     (spi_cmd),
      .angle       (angle),
      .angle_vld   (angle_vld),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (angle_vld === 1'b1)
         vld_count++;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_checks();
      chk1 ("rst_wrt_cmd",     wrt_cmd,     1'b0);
      chk16("rst_spi_cmd",     spi_cmd,     16'h0000);
      chk16("rst_angle",       angle,       16'h0000);
      chk1 ("rst_angle_vld",   angle_vld,   1'b0);
      chk1 ("rst_busy",        busy,        1'b0);
      chk1 ("rst_timeout_err", timeout_err, 1'b0);
      chk1 ("rst_overrun",     overrun,     1'b0);
   endtask

   // Waits for wrt_cmd, checks the command word, then acts as SPI slave answering
   // d cycles after wrt_cmd. Returns one cycle after spi_done (or right after the
   // wrt_cmd cycle when no answer is given).
   task automatic frame(input int d, input logic [15:0] resp, input bit give_done, input bit drop_en);
      logic [15:0] e;
      for (int n = 0; n < 64 && wrt_cmd !== 1'b1; n++)
         step();
      chk1("wrt_cmd_seen", wrt_cmd, 1'b1);
      if (wrt_cmd === 1'b1) begin
         e = 16'hxxxx;
         if (cmd_q.size() > 0)
            e = cmd_q.pop_front();
         chk16("spi_cmd", spi_cmd, e);
         chk1("busy_in_frame", busy, 1'b1);
         if (drop_en)
            en = 1'b0;
         step();
         chk1("wrt_cmd_pulse", wrt_cmd, 1'b0);
         chk16("spi_cmd_hold", spi_cmd, e);
         if (give_done) begin
            repeat (d - 1) step();
            spi_resp = resp;
            spi_done = 1'b1;
            step();
            spi_done = 1'b0;
            spi_resp = 16'hDEAD;
         end
      end
   endtask

   task automatic publish();
      logic [15:0] e;
      e = 16'hxxxx;
      if (ang_q.size() > 0)
         e = ang_q.pop_front();
      exp_vld++;
      chk1 ("angle_vld_latency", angle_vld, 1'b1);
      chk16("angle",             angle,     e);
      chk1 ("timeout_err_clr",   timeout_err, 1'b0);
      $display("publish angle=%h expected=%h", angle, e);
      step();
      chk1("angle_vld_single", angle_vld, 1'b0);
      chk1("busy_after_pub",   busy,      1'b0);
   endtask

   task automatic pair(input logic [15:0] raw, input logic [15:0] exp_angle);
      cmd_q.push_back(16'hA000);
      cmd_q.push_back(16'h0000);
      ang_q.push_back(exp_angle);
      frame(2, 16'hBEEF, 1'b1, 1'b0);
      frame(2, raw, 1'b1, 1'b0);
      publish();
   endtask

   initial begin
      int w;

      // Reset state
      repeat (2) step();
      reset_checks();
      rst_n = 1'b1;
      step();

      // Basic read with zero offset
      en = 1'b1;
      pair(16'h1234, 16'h1234);
      chk1("no_overrun_short_frames", overrun, 1'b0);

      // Calibration with modulo wrap
      cal_offset = 16'h0100;
      cal_load   = 1'b1;
      step();
      cal_load   = 1'b0;
      pair(16'h0080, 16'hFF80);

      // en dropped during WAIT_RD: READ frame completes, no NOP frame
      cmd_q.push_back(16'hA000);
      frame(2, 16'hBEEF, 1'b1, 1'b1);
      chk1("en_drop_busy", busy, 1'b0);
      w = 0;
      repeat (12) begin
         step();
         if (wrt_cmd === 1'b1) w++;
      end
      chk16("en_drop_no_nop", 16'(w), 16'd0);
      chk1("en_drop_overrun", overrun, 1'b0);
      $display("en_drop busy=%b extra_wrt=%0d", busy, w);

      // Missing spi_done: timeout exactly after TO cycles, overrun, then retry
      en = 1'b1;
      cmd_q.push_back(16'hA000);
      frame(0, 16'h0000, 1'b0, 1'b0);
      w = 0;
      repeat (TO - 1) begin
         step();
         if (wrt_cmd === 1'b1) w++;
      end
      chk1("timeout_not_early", timeout_err, 1'b0);
      step();
      chk1("timeout_err_set",  timeout_err, 1'b1);
      chk1("timeout_busy_clr", busy,        1'b0);
      chk1("overrun_set",      overrun,     1'b1);
      chk16("no_wrt_while_busy", 16'(w), 16'd0);
      $display("timeout timeout_err=%b overrun=%b", timeout_err, overrun);
      pair(16'h4321, 16'h4221);

      // spi_done on the last allowed cycle wins over the timeout
      cmd_q.push_back(16'hA000);
      cmd_q.push_back(16'h0000);
      ang_q.push_back(16'h0080);
      frame(TO, 16'hBEEF, 1'b1, 1'b0);
      chk1("done_wins_no_err", timeout_err, 1'b0);
      chk1("done_wins_nop_wrt", wrt_cmd, 1'b1);
      frame(2, 16'h0180, 1'b1, 1'b0);
      publish();

      // cal_load coincident with PUBLISH uses the old offset
      cmd_q.push_back(16'hA000);
      cmd_q.push_back(16'h0000);
      ang_q.push_back(16'h0200);
      frame(2, 16'hBEEF, 1'b1, 1'b0);
      frame(2, 16'h0300, 1'b1, 1'b0);
      cal_offset = 16'h0200;
      cal_load   = 1'b1;
      publish();
      cal_load   = 1'b0;
      pair(16'h0300, 16'h0100);

      // Reset in WAIT_NOP
      cmd_q.push_back(16'hA000);
      cmd_q.push_back(16'h0000);
      frame(2, 16'hBEEF, 1'b1, 1'b0);
      frame(0, 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      reset_checks();
      step();
      step();
      rst_n = 1'b1;
      $display("reset_mid_frame busy=%b overrun=%b angle=%h", busy, overrun, angle);
      pair(16'h0300, 16'h0300);

      step();
      chk16("angle_vld_count", 16'(vld_count), 16'(exp_vld));
      chk16("cmd_q_empty", 16'(cmd_q.size()), 16'd0);
      chk16("ang_q_empty", 16'(ang_q.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
